// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Purpose  : Shared defaults and divisor type for the clock divider bank.
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int unsigned C_DIV_W_DEFAULT       = 8;
    localparam int unsigned C_LOCK_CYCLES_DEFAULT = 16;

    typedef logic [C_DIV_W_DEFAULT-1:0] div_t;

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_chan
// Purpose  : One divider channel: counter, pending shadow, apply logic and
//            registered strobe / square-wave outputs.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W = C_DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_cfg_load,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_stb,
    output logic             o_clk_out,
    output logic             o_busy
);

    localparam logic [DIV_W-1:0] C_ONE   = DIV_W'(1);
    localparam logic [DIV_W:0]   C_ONE_X = (DIV_W+1)'(1);

    logic [DIV_W-1:0] r_active;
    logic [DIV_W-1:0] r_pending;
    logic [DIV_W-1:0] r_count;
    logic             r_busy;
    logic             r_stb;
    logic             r_clk_out;

    logic             w_run;
    logic             w_wrap;
    logic             w_apply;
    logic [DIV_W:0]   w_half;

    assign w_run  = i_en && (r_active != '0);
    assign w_wrap = w_run && (r_count == (r_active - C_ONE));
    assign w_half = ({1'b0, r_active} + C_ONE_X) >> 1;

    // A running channel only switches divisor on its wrap so no phase is cut
    // short; an idle channel has no phase to protect and switches at once.
    assign w_apply = i_en && r_busy && (w_wrap || (r_active == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= '0;
            r_pending <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_stb     <= 1'b0;
            r_clk_out <= 1'b0;
        end else begin
            if (!i_en) begin
                r_count   <= '0;
                r_stb     <= 1'b0;
                r_clk_out <= 1'b0;
            end else begin
                r_stb     <= w_wrap;
                r_clk_out <= w_run && ({1'b0, r_count} < w_half);
                if (w_apply || w_wrap || !w_run) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + C_ONE;
                end
            end

            if (w_apply) begin
                r_active <= r_pending;
            end

            // A load landing on the apply edge is compared against the divisor
            // being applied, not the one being retired.
            if (i_cfg_load) begin
                r_pending <= i_div;
                r_busy    <= (i_div != (w_apply ? r_pending : r_active));
            end else if (w_apply) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_stb     = r_stb;
    assign o_clk_out = r_clk_out;
    assign o_busy    = r_busy;

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank
// Purpose  : Bank of NCH independent clock-enable dividers with shadowed
//            reconfiguration and a common lock indicator.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned NCH         = 2,
    parameter int unsigned DIV_W       = $bits(div_t),
    parameter int unsigned LOCK_CYCLES = C_LOCK_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NCH*DIV_W-1:0] div_cfg,
    input  logic               cfg_load,
    output logic [NCH-1:0]     stb,
    output logic [NCH-1:0]     clk_out,
    output logic               lock,
    output logic [NCH-1:0]     busy
);

    localparam int unsigned             C_SETTLE_W   = $clog2(LOCK_CYCLES + 1);
    localparam logic [C_SETTLE_W-1:0]   C_SETTLE_MAX = C_SETTLE_W'(LOCK_CYCLES);
    localparam logic [C_SETTLE_W-1:0]   C_SETTLE_ONE = C_SETTLE_W'(1);

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    logic [C_SETTLE_W-1:0] r_settle;
    logic [C_SETTLE_W-1:0] w_settle_nxt;
    logic                  r_lock;

    // Assertion propagates asynchronously; release waits two clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            clk_div_chan #(
                .DIV_W (DIV_W)
            ) u_chan (
                .clk        (clk),
                .rst_n      (w_rst_n),
                .i_en       (en),
                .i_cfg_load (cfg_load),
                .i_div      (div_cfg[i*DIV_W +: DIV_W]),
                .o_stb      (stb[i]),
                .o_clk_out  (clk_out[i]),
                .o_busy     (busy[i])
            );
        end
    endgenerate

    always_comb begin
        w_settle_nxt = r_settle;
        if (!en || cfg_load || (|busy)) begin
            w_settle_nxt = '0;
        end else if (r_settle != C_SETTLE_MAX) begin
            w_settle_nxt = r_settle + C_SETTLE_ONE;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_settle <= '0;
            r_lock   <= 1'b0;
        end else begin
            r_settle <= w_settle_nxt;
            r_lock   <= (w_settle_nxt == C_SETTLE_MAX);
        end
    end

    assign lock = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_bank
// Purpose  : Scoreboard bench for clk_div_bank using directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

    localparam int NCH   = 2;
    localparam int DIV_W = 8;
    localparam int LOCK  = 16;

    localparam int S_STB  = 0;
    localparam int S_CLK  = 1;
    localparam int S_BUSY = 2;
    localparam int S_LOCK = 3;

    logic                 clk      = 1'b0;
    logic                 rst_n    = 1'b0;
    logic                 en       = 1'b0;
    logic                 cfg_load = 1'b0;
    logic [NCH*DIV_W-1:0] div_cfg  = '0;
    logic [NCH-1:0]       stb;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       busy;
    logic                 lock;

    clk_div_bank #(
        .NCH         (NCH),
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_cfg  (div_cfg),
        .cfg_load (cfg_load),
        .stb      (stb),
        .clk_out  (clk_out),
        .lock     (lock),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int sig;
        int idx;
        bit val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic string sig_name(int s);
        case (s)
            S_STB:   return "stb";
            S_CLK:   return "clk_out";
            S_BUSY:  return "busy";
            default: return "lock";
        endcase
    endfunction

    function automatic logic actual(int s, int i);
        case (s)
            S_STB:   return stb[i];
            S_CLK:   return clk_out[i];
            S_BUSY:  return busy[i];
            default: return lock;
        endcase
    endfunction

    function automatic void check(string name, int idx, logic act, logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s[%0d] cyc %0d: got %b, expected %b", name, idx, cyc, act, want);
        end
    endfunction

    function automatic void expect_bit(int c, int s, int i, bit v);
        sb.push_back('{c, s, i, v});
    endfunction

    // Expected outputs for a channel whose counter shows 0 in cycle c0;
    // outputs trail the counter by one cycle.
    function automatic void expect_wave(int ch, int d, int c0, int from, int to);
        for (int c = from; c <= to; c++) begin
            int ph;
            if (d == 0) begin
                expect_bit(c, S_STB, ch, 1'b0);
                expect_bit(c, S_CLK, ch, 1'b0);
            end else begin
                ph = (c - 1 - c0) % d;
                expect_bit(c, S_STB, ch, ph == d - 1);
                expect_bit(c, S_CLK, ch, ph < (d + 1) / 2);
            end
        end
    endfunction

    // Monitor: compares every expectation due in the current cycle.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sig_name(sb[i].sig), sb[i].idx, actual(sb[i].sig, sb[i].idx), sb[i].val);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale %s[%0d] due cyc %0d never sampled", sig_name(sb[i].sig), sb[i].idx, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain();
        int budget;
        budget = 300;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic load(input int d0, input int d1);
        div_cfg  = {DIV_W'(d1), DIV_W'(d0)};
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    // Reset, release, enable and load both divisors; c0 is the first cycle
    // in which both counters show 0 on the loaded divisors.
    task automatic start_cfg(input int d0, input int d1, output int c0);
        int m;
        int n;
        @(negedge clk);
        rst_n    = 1'b0;
        en       = 1'b0;
        cfg_load = 1'b0;
        m = cyc;
        for (int c = m + 1; c <= m + 6; c++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                expect_bit(c, S_STB, ch, 1'b0);
                expect_bit(c, S_CLK, ch, 1'b0);
                expect_bit(c, S_BUSY, ch, 1'b0);
            end
            expect_bit(c, S_LOCK, 0, 1'b0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n  = cyc;
        en = 1'b1;
        expect_bit(n + 1, S_BUSY, 0, d0 != 0);
        expect_bit(n + 1, S_BUSY, 1, d1 != 0);
        expect_bit(n + 2, S_BUSY, 0, 1'b0);
        expect_bit(n + 2, S_BUSY, 1, 1'b0);
        c0 = n + 2;
        load(d0, d1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int b;
        int t;

        // Basic division 3 / 4 and initial lock.
        start_cfg(3, 4, c0);
        expect_wave(0, 3, c0, c0 + 1, c0 + 24);
        expect_wave(1, 4, c0, c0 + 1, c0 + 24);
        expect_bit(c0 + 15, S_LOCK, 0, 1'b0);
        expect_bit(c0 + 16, S_LOCK, 0, 1'b1);
        expect_bit(c0 + 24, S_LOCK, 0, 1'b1);
        drain();

        // 4 -> 6 loaded at count 1.
        start_cfg(4, 4, c0);
        b = c0 + 20;
        expect_wave(0, 4, c0, c0 + 1, b + 4);
        expect_wave(0, 6, b + 4, b + 5, b + 30);
        expect_wave(1, 4, c0, c0 + 1, b + 30);
        expect_bit(b + 2, S_BUSY, 0, 1'b1);
        expect_bit(b + 3, S_BUSY, 0, 1'b1);
        expect_bit(b + 4, S_BUSY, 0, 1'b0);
        expect_bit(b + 2, S_BUSY, 1, 1'b0);
        expect_bit(b + 1, S_LOCK, 0, 1'b1);
        expect_bit(b + 2, S_LOCK, 0, 1'b0);
        expect_bit(b + 19, S_LOCK, 0, 1'b0);
        expect_bit(b + 20, S_LOCK, 0, 1'b1);
        wait_cyc(b + 1);
        load(6, 4);
        drain();

        // Load on the wrap of D=2: old divisor governs that wrap.
        start_cfg(2, 4, c0);
        t = c0 + 5;
        expect_wave(0, 2, c0, c0 + 1, t + 3);
        expect_wave(0, 5, t + 3, t + 4, t + 25);
        expect_bit(t + 1, S_BUSY, 0, 1'b1);
        expect_bit(t + 2, S_BUSY, 0, 1'b1);
        expect_bit(t + 3, S_BUSY, 0, 1'b0);
        wait_cyc(t);
        load(5, 4);
        drain();

        // Two loads in one period: only the latest applies.
        start_cfg(4, 4, c0);
        b = c0 + 4;
        expect_wave(0, 4, c0, c0 + 1, b + 4);
        expect_wave(0, 9, b + 4, b + 5, b + 30);
        expect_bit(b + 1, S_BUSY, 0, 1'b1);
        expect_bit(b + 3, S_BUSY, 0, 1'b1);
        expect_bit(b + 4, S_BUSY, 0, 1'b0);
        wait_cyc(b);
        load(7, 4);
        load(9, 4);
        drain();

        // Disabled channel, then D=1, then asynchronous reset mid-run.
        start_cfg(0, 4, c0);
        t = c0 + 10;
        expect_wave(0, 0, c0, c0 + 1, t + 2);
        expect_wave(0, 1, t + 2, t + 3, t + 13);
        expect_bit(t + 1, S_BUSY, 0, 1'b1);
        expect_bit(t + 1, S_BUSY, 1, 1'b0);
        expect_bit(t + 2, S_BUSY, 0, 1'b0);
        wait_cyc(t);
        load(1, 4);
        wait_cyc(t + 13);
        drain();
        rst_n = 1'b0;
        #1;
        for (int ch = 0; ch < NCH; ch++) begin
            check("rst_async_stb", ch, stb[ch], 1'b0);
            check("rst_async_clk_out", ch, clk_out[ch], 1'b0);
            check("rst_async_busy", ch, busy[ch], 1'b0);
        end
        check("rst_async_lock", 0, lock, 1'b0);

        // en low/high: outputs cleared, divisors kept, phases realigned.
        start_cfg(3, 4, c0);
        t = c0 + 30;
        expect_wave(0, 3, c0, c0 + 1, t);
        expect_wave(1, 4, c0, c0 + 1, t);
        expect_bit(t, S_LOCK, 0, 1'b1);
        expect_bit(t + 1, S_LOCK, 0, 1'b0);
        for (int c = t + 1; c <= t + 5; c++) begin
            expect_bit(c, S_STB, 0, 1'b0);
            expect_bit(c, S_CLK, 0, 1'b0);
            expect_bit(c, S_STB, 1, 1'b0);
            expect_bit(c, S_CLK, 1, 1'b0);
        end
        expect_wave(0, 3, t + 5, t + 6, t + 30);
        expect_wave(1, 4, t + 5, t + 6, t + 30);
        expect_bit(t + 20, S_LOCK, 0, 1'b0);
        expect_bit(t + 21, S_LOCK, 0, 1'b1);
        wait_cyc(t);
        en = 1'b0;
        wait_cyc(t + 5);
        en = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
